ultrasonic_scheduler: RTL and testbench
=======================================

Name: ultrasonic_scheduler

Overview:
- Time-multiplexes the six ultrasonic rangefinders: fr, fl, r, l, bl, br.
- Fires one sensor at a time, round-robin, so no two pings share the acoustic channel.
- Measures each echo pulse width and converts it to centimetres without a divider.
- Holds the latest 9-bit cm value per sensor; these feed the *sensorincm PIO inputs of the Nios system.

Parameters:
- NUM_SENSORS, 6, number of rangefinders. Index order: 0=fr, 1=fl, 2=r, 3=l, 4=bl, 5=br.
- TRIG_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz).
- CYCLES_PER_CM, 2915, clocks of echo-high per cm (58.3 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000, maximum wait for the echo rising edge, and maximum echo width.
- GUARD_CYCLES, 500000, quiet time after each measurement before the next trigger.

Ports:
- clk_clk, in, 1, system clock.
- reset_reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, run the scan while high.
- echo, in, NUM_SENSORS, raw echo lines. Asynchronous; each bit passes through a 2-flop synchroniser.
- trig, out, NUM_SENSORS, trigger lines. One-hot or zero.
- dist_cm, out, NUM_SENSORS*9, packed distances. Sensor i occupies bits [9i+8:9i].
- timeout_flags, out, NUM_SENSORS, bit i = last measurement of sensor i timed out.
- meas_valid, out, 1, one-cycle strobe when a result is written.
- meas_idx, out, 3, index of the sensor written or currently active.

Behaviour:
- Reset, asynchronous and immediate, including mid-measurement:
  - state=IDLE, trig=0, every dist_cm field=511, timeout_flags=0, meas_valid=0, meas_idx=0.
  - All counters = 0; synchroniser flops = 0.
- Only the active sensor's synchronised echo is observed; all other echo bits are ignored.
- State machine, one counter cnt:
  - IDLE: trig=0. If enable=1, go to TRIG with cnt=0.
  - TRIG: trig[meas_idx]=1 for exactly TRIG_CYCLES clocks, then WAIT_RISE with cnt=0.
  - WAIT_RISE:
    - Synchronised echo=1: go to MEASURE, clear cm and sub-counter.
    - cnt reaches TIMEOUT_CYCLES-1: record timeout, go to GUARD.
  - MEASURE, each clock with synchronised echo=1:
    - sub += 1; when sub = CYCLES_PER_CM-1, sub=0 and cm += 1.
    - cm saturates at 511.
    - If the total echo-high count reaches TIMEOUT_CYCLES: record timeout, go to GUARD.
  - MEASURE, synchronised echo falling edge: record cm (truncated), go to GUARD.
  - GUARD: wait GUARD_CYCLES clocks, then:
    - meas_idx = (meas_idx==NUM_SENSORS-1) ? 0 : meas_idx+1.
    - If enable=1, go to TRIG; else go to IDLE.
- Record:
  - Same clock as the falling-edge detect or timeout detect.
  - Writes dist_cm[meas_idx] (cm, or 511 on timeout) and timeout_flags[meas_idx] (0, or 1 on timeout).
  - Pulses meas_valid for that one clock, with meas_idx still equal to the written sensor.
- Latency: the result appears 3 clocks after the raw echo falls (2 synchroniser flops + edge register).
- enable deasserted mid-cycle: the current measurement and guard complete normally, then IDLE. No partial result is discarded.
- Echo already high when WAIT_RISE is entered (stale echo): counts as the rising edge. The sensor hardware prevents this via GUARD_CYCLES.
- Width rules:
  - cnt is wide enough for max(TIMEOUT_CYCLES, GUARD_CYCLES).
  - sub is wide enough for CYCLES_PER_CM.
  - cm is 9 bits, saturating.
- dist_cm fields are held between writes; there are no other updates.

Test Plan:
Bench parameters: TRIG_CYCLES=5, CYCLES_PER_CM=4, TIMEOUT_CYCLES=200, GUARD_CYCLES=10.
1. Reset, then enable=1 with a 40-clock echo on sensor 0 → trig[0] high for exactly 5 clocks; dist_cm[8:0]=10; meas_valid pulses once with meas_idx=0; timeout_flags[0]=0.
2. Echo widths 43, 3 and 0 (no pulse) on sensors 1, 2 and 3 → dist values 10, 0 and 511; timeout_flags = 6'b001000, with only bit 3 set; meas_valid pulses at idx 1, 2, 3 in order.
3. Full scan of 6 sensors, then a 7th trigger → trig goes one-hot 0..5 and then returns to bit 0; no two trig bits are ever high together; no trig while any echo is being measured.
4. Echo on a non-active sensor (sensor 4 pulsed while idx=1 is measuring) → no effect on idx 1's result; dist_cm[4] unchanged at 511.
5. Echo held high 250 clocks → record at total count 200: field=511, timeout flag=1. Also: cm saturation check with CYCLES_PER_CM=1 and a 199-clock echo → 199, not a wrap.
6. reset_reset_n pulsed low mid-MEASURE → outputs return to reset values immediately; after release the scan restarts at idx 0. Separately: enable dropped during TRIG → that measurement completes, then IDLE with trig=0.

Source files
------------

// File: rtl/ultrasonic_scheduler.sv
// Round-robin ultrasonic rangefinder scheduler: fires one sensor at a time,
// measures its echo width and converts it to centimetres with a sub-counter.
module ultrasonic_scheduler #(
  parameter int NUM_SENSORS    = 6,
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2915,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GUARD_CYCLES   = 500000
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     enable,
  input  logic [NUM_SENSORS-1:0]   echo,
  output logic [NUM_SENSORS-1:0]   trig,
  output logic [NUM_SENSORS*9-1:0] dist_cm,
  output logic [NUM_SENSORS-1:0]   timeout_flags,
  output logic                     meas_valid,
  output logic [2:0]               meas_idx,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GUARD     = 3'd4
  } state_t;

  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > GUARD_CYCLES)
      ? ((TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES)
      : ((GUARD_CYCLES > TRIG_CYCLES) ? GUARD_CYCLES : TRIG_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [2:0]       LAST_IDX     = 3'(NUM_SENSORS - 1);
  localparam logic [8:0]       CM_MAX       = 9'd511;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [SUB_W-1:0]       sub, sub_n;
  logic [8:0]             cm, cm_n;
  logic [2:0]             idx_n;
  logic [NUM_SENSORS-1:0] echo_s1, echo_s2;
  logic                   echo_q;
  logic                   echo_act;
  logic                   rec, rec_to;
  logic [8:0]             rec_cm;

  // Only the sensor currently being scanned is observed.
  assign echo_act  = echo_s2[meas_idx];
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sub_n   = sub;
    cm_n    = cm;
    idx_n   = meas_idx;
    rec     = 1'b0;
    rec_to  = 1'b0;
    rec_cm  = cm;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n = TRIG;
          cnt_n   = '0;
        end
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_n = WAIT_RISE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (echo_act) begin
          state_n = MEASURE;
          cnt_n   = '0;
          sub_n   = '0;
          cm_n    = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          rec     = 1'b1;
          rec_to  = 1'b1;
          state_n = GUARD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      MEASURE: begin
        // echo_q lags echo_act by one clock, so the clock that sees the
        // synchronised fall still counts the last high cycle.
        if (echo_q) begin
          cnt_n = cnt + 1'b1;
          if (sub == SUB_LAST) begin
            sub_n = '0;
            if (cm != CM_MAX) cm_n = cm + 9'd1;
          end else begin
            sub_n = sub + 1'b1;
          end
        end
        if (echo_q && cnt == TIMEOUT_LAST) begin
          rec     = 1'b1;
          rec_to  = 1'b1;
          state_n = GUARD;
          cnt_n   = '0;
        end else if (!echo_act) begin
          rec     = 1'b1;
          rec_cm  = cm_n;
          state_n = GUARD;
          cnt_n   = '0;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          idx_n   = (meas_idx == LAST_IDX) ? 3'd0 : meas_idx + 3'd1;
          state_n = enable ? TRIG : IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // meas_valid is a one-cycle strobe with no back-pressure; dist_cm,
  // timeout_flags and meas_idx are stable while it is high.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      sub           <= '0;
      cm            <= '0;
      echo_s1       <= '0;
      echo_s2       <= '0;
      echo_q        <= 1'b0;
      trig          <= '0;
      dist_cm       <= '1;
      timeout_flags <= '0;
      meas_valid    <= 1'b0;
      meas_idx      <= 3'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sub        <= sub_n;
      cm         <= cm_n;
      echo_s1    <= echo;
      echo_s2    <= echo_s1;
      echo_q     <= echo_act;
      meas_valid <= rec;
      meas_idx   <= idx_n;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        trig[i] <= (state_n == TRIG) && (idx_n == 3'(i));
        if (rec && meas_idx == 3'(i)) begin
          dist_cm[9*i +: 9] <= rec_to ? CM_MAX : rec_cm;
          timeout_flags[i]  <= rec_to;
        end
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Randomised bench for ultrasonic_scheduler: two instances (4 and 1 clocks per cm)
// share stimulus and are scored against a width-to-distance reference model.
module tb_ultrasonic_scheduler;

  localparam int N       = 6;
  localparam int TRIG_C  = 5;
  localparam int CPCM    = 4;
  localparam int TMO     = 200;
  localparam int GUARD_C = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] echo = '0;

  logic [N-1:0]   trig_a, trig_b, flags_a, flags_b;
  logic [N*9-1:0] dist_a, dist_b;
  logic           valid_a, valid_b;
  logic [2:0]     idx_a, idx_b, state_a, state_b;

  ultrasonic_scheduler #(
    .NUM_SENSORS(N), .TRIG_CYCLES(TRIG_C), .CYCLES_PER_CM(CPCM),
    .TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GUARD_C)
  ) u_dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .echo(echo),
    .trig(trig_a), .dist_cm(dist_a), .timeout_flags(flags_a),
    .meas_valid(valid_a), .meas_idx(idx_a), .dbg_state(state_a)
  );

  ultrasonic_scheduler #(
    .NUM_SENSORS(N), .TRIG_CYCLES(TRIG_C), .CYCLES_PER_CM(1),
    .TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GUARD_C)
  ) u_dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .echo(echo),
    .trig(trig_b), .dist_cm(dist_b), .timeout_flags(flags_b),
    .meas_valid(valid_b), .meas_idx(idx_b), .dbg_state(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model and scoreboard
  typedef struct {
    int idx;
    int cm_a;
    int cm_b;
    bit to;
  } meas_t;

  meas_t        exp_q[$];
  int           mdist_a[N];
  int           mdist_b[N];
  logic [N-1:0] mflags;
  int           exp_idx;
  bit           busy;
  logic [N-1:0] one = 1;

  function automatic int ref_cm(input int w, input int cpcm);
    int v;
    if (w == 0 || w >= TMO) return 511;
    v = w / cpcm;
    return (v > 511) ? 511 : v;
  endfunction

  function automatic logic [N*9-1:0] pack_dist(input bit sel_b);
    logic [N*9-1:0] v;
    for (int i = 0; i < N; i++) v[9*i +: 9] = 9'(sel_b ? mdist_b[i] : mdist_a[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mdist_a[i] = 511;
      mdist_b[i] = 511;
    end
    mflags  = '0;
    exp_idx = 0;
    busy    = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trig"},  trig_a,  '0);
    check({tag, "_dist"},  dist_a,  {(N*9){1'b1}});
    check({tag, "_distb"}, dist_b,  {(N*9){1'b1}});
    check({tag, "_flags"}, flags_a, '0);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_idx"},   idx_a,   0);
    check({tag, "_state"}, state_a, 0);
  endtask

  always @(negedge clk) begin
    meas_t m;
    if (rst_n) begin
      if (trig_b !== trig_a) check("trig_pair", trig_b, trig_a);
      if (trig_a != '0) begin
        check("trig_onehot", 64'($onehot(trig_a)), 1);
        check("trig_while_busy", 64'(busy), 0);
      end
      if (valid_a || valid_b) begin
        check("valid_pair", valid_b, valid_a);
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          m = exp_q.pop_front();
          mdist_a[m.idx] = m.cm_a;
          mdist_b[m.idx] = m.cm_b;
          mflags[m.idx]  = m.to;
          check("meas_idx", idx_a, m.idx);
          check("dist_a", dist_a, pack_dist(1'b0));
          check("dist_b", dist_b, pack_dist(1'b1));
          check("flags_a", flags_a, mflags);
          check("flags_b", flags_b, mflags);
          exp_idx = (m.idx + 1) % N;
          busy    = 1'b0;
        end
      end
    end
  end

  // driver: one scan slot with an echo of width w after delay d
  task automatic run_meas(input int w, input int d, input bit side, input bit drop_en);
    meas_t m;
    int    k, sj, a, b;
    k = 0;
    while (trig_a == '0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (trig_a == '0) begin
      check("trig_wait", 0, 1);
      return;
    end
    check("trig_sel", trig_a, 64'(one << exp_idx));
    if (drop_en) enable = 1'b0;
    k = 0;
    while (trig_a != '0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("trig_width", k, TRIG_C);
    m.idx  = exp_idx;
    m.cm_a = ref_cm(w, CPCM);
    m.cm_b = ref_cm(w, 1);
    m.to   = (w == 0 || w >= TMO);
    exp_q.push_back(m);
    busy = 1'b1;
    sj = (m.idx + 3) % N;
    a  = (w > 0) ? $urandom_range(0, w - 1) : 0;
    b  = (w > 0) ? a + $urandom_range(1, w - a) : 0;
    repeat (d) @(negedge clk);
    for (int c = 0; c < w && busy; c++) begin
      @(negedge clk);
      echo = (one << m.idx) | ((side && c >= a && c < b) ? (one << sj) : '0);
    end
    @(negedge clk);
    echo = '0;
    k = 0;
    while (busy && k < TMO + 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      check("valid_wait", 0, 1);
      busy = 1'b0;
    end
  endtask

  initial begin
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    run_meas(40, 3, 1'b0, 1'b0);
    check("dist0_40clk", dist_a[8:0], 10);
    check("flag0", flags_a[0], 0);
    run_meas(43, 5, 1'b1, 1'b0);
    check("dist4_untouched", dist_a[36 +: 9], 511);
    run_meas(3, 2, 1'b0, 1'b0);
    run_meas(0, 0, 1'b0, 1'b0);
    check("flags_after_s3", flags_a, 6'b001000);
    run_meas($urandom_range(1, 150), $urandom_range(0, 20), 1'b1, 1'b0);
    run_meas($urandom_range(1, 150), $urandom_range(0, 20), 1'b1, 1'b0);
    run_meas($urandom_range(1, 150), $urandom_range(0, 20), 1'b0, 1'b0);
    run_meas(250, 1, 1'b0, 1'b0);
    check("timeout_flag1", flags_a[1], 1);
    run_meas(199, 4, 1'b1, 1'b0);
    check("sat_b_199", dist_b[18 +: 9], 199);
    for (int i = 0; i < 12; i++)
      run_meas($urandom_range(0, 230), $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b0);

    // asynchronous reset in the middle of an echo measurement
    k = 0;
    while (trig_a == '0 && k < 3000) begin @(negedge clk); k++; end
    k = 0;
    while (trig_a != '0 && k < 100) begin @(negedge clk); k++; end
    echo = one << exp_idx;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    echo = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_meas(30, 2, 1'b0, 1'b0);
    check("restart_dist0", dist_a[8:0], 7);

    // enable dropped while the trigger is active
    run_meas(20, 1, 1'b0, 1'b1);
    k = 0;
    repeat (GUARD_C + 30) begin
      @(negedge clk);
      if (trig_a != '0) k++;
    end
    check("trig_after_disable", k, 0);
    check("idle_after_disable", state_a, 0);
    check("idx_after_disable", idx_a, exp_idx);
    check("dist1_after_disable", dist_a[9 +: 9], 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
